// File: rtl/imem_responder_if.sv
// Instruction-fetch bus between the core (master) and the instruction memory (slave).
interface imem_responder_if;
    logic        exIns_ren;
    logic [31:0] exIns_addr;
    logic        exIns_valid;
    logic [31:0] exIns_in;
    logic        fetch_err;

    modport master (
        output exIns_ren,
        output exIns_addr,
        input  exIns_valid,
        input  exIns_in,
        input  fetch_err
    );

    modport slave (
        input  exIns_ren,
        input  exIns_addr,
        output exIns_valid,
        output exIns_in,
        output fetch_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: word-addressed array with fixed-latency, in-order
// fetch responses, bad-fetch flagging and a side load port.
module imem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  nrst,
    imem_responder_if.slave       bus,
    input  logic                  ld_wen,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic [2:0]            outstanding
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN  = 32'd4 << DEPTH_LOG2;

    // Misaligned, or past the end of the array (addresses below the base wrap to huge offsets).
    function automatic logic fetch_bad(input logic [31:0] off_in);
        return (off_in[1:0] != 2'b00) || (off_in >= SPAN);
    endfunction

    logic [31:0] mem [DEPTH];

    logic [31:0] off;
    logic        bad;
    logic [31:0] rd_word;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [31:0]        dat_q [LATENCY];
    logic [31:0]        dat_d [LATENCY];
    logic [2:0]         outstanding_q, outstanding_d;

    always_comb begin
        off     = bus.exIns_addr - BASE_ADDR;
        bad     = fetch_bad(off);
        rd_word = mem[off[DEPTH_LOG2+1:2]];
    end

    // Stage 0 captures the array read; later stages only delay. Data moves only
    // with a valid entry so the output word holds between responses.
    always_comb begin
        vld_d = '0;
        err_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            dat_d[i] = dat_q[i];
        end
        vld_d[0] = bus.exIns_ren;
        err_d[0] = bus.exIns_ren & bad;
        if (bus.exIns_ren) begin
            dat_d[0] = bad ? NOP_INST : rd_word;
        end
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            if (vld_q[i-1]) begin
                dat_d[i] = dat_q[i-1];
            end
        end
        outstanding_d = outstanding_q + {2'b00, bus.exIns_ren} - {2'b00, vld_d[LATENCY-1]};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_q         <= '0;
            err_q         <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q         <= vld_d;
            err_q         <= err_d;
            outstanding_q <= outstanding_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // The array is never cleared by reset; writes land after the same-edge read.
    always_ff @(posedge clk) begin
        if (ld_wen) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign bus.exIns_valid = vld_q[LATENCY-1];
    assign bus.exIns_in    = dat_q[LATENCY-1];
    assign bus.fetch_err   = err_q[LATENCY-1];
    assign outstanding     = outstanding_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: four configurations share one stimulus stream and are
// compared every cycle against a cycle-history reference model.
module tb_imem_responder;

    localparam int ND = 4;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 3) ? 32'h8000_0000 : 32'h0000_0000;
    endfunction

    logic        clk;
    logic        nrst;
    logic        ren;
    logic [31:0] aoff;
    logic        ld_wen;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    imem_responder_if b0 ();
    imem_responder_if b1 ();
    imem_responder_if b2 ();
    imem_responder_if b3 ();

    assign b0.exIns_ren  = ren;
    assign b1.exIns_ren  = ren;
    assign b2.exIns_ren  = ren;
    assign b3.exIns_ren  = ren;
    assign b0.exIns_addr = aoff + base_of(0);
    assign b1.exIns_addr = aoff + base_of(1);
    assign b2.exIns_addr = aoff + base_of(2);
    assign b3.exIns_addr = aoff + base_of(3);

    logic [2:0] o0, o1, o2, o3;

    imem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(32'h0000_0000), .NOP_INST(32'h0000_0013)) u_l1 (
        .clk(clk), .nrst(nrst), .bus(b0), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .outstanding(o0));
    imem_responder #(.DEPTH_LOG2(10), .LATENCY(3), .BASE_ADDR(32'h0000_0000), .NOP_INST(32'h0000_0013)) u_l3 (
        .clk(clk), .nrst(nrst), .bus(b1), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .outstanding(o1));
    imem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .BASE_ADDR(32'h0000_0000), .NOP_INST(32'h0000_0013)) u_l4 (
        .clk(clk), .nrst(nrst), .bus(b2), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .outstanding(o2));
    imem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h8000_0000), .NOP_INST(32'h0000_0013)) u_l2b (
        .clk(clk), .nrst(nrst), .bus(b3), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .outstanding(o3));

    logic        got_v [ND];
    logic [31:0] got_d [ND];
    logic        got_e [ND];
    logic [2:0]  got_o [ND];

    assign got_v[0] = b0.exIns_valid;  assign got_d[0] = b0.exIns_in;  assign got_e[0] = b0.fetch_err;  assign got_o[0] = o0;
    assign got_v[1] = b1.exIns_valid;  assign got_d[1] = b1.exIns_in;  assign got_e[1] = b1.fetch_err;  assign got_o[1] = o1;
    assign got_v[2] = b2.exIns_valid;  assign got_d[2] = b2.exIns_in;  assign got_e[2] = b2.fetch_err;  assign got_o[2] = o2;
    assign got_v[3] = b3.exIns_valid;  assign got_d[3] = b3.exIns_in;  assign got_e[3] = b3.fetch_err;  assign got_o[3] = o3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a history of what each request at edge e should return,
    // looked up LATENCY-1 edges later.
    logic [31:0] mem_m [1024];
    bit          hv [ND][8];
    bit          he [ND][8];
    logic [31:0] hd [ND][8];
    logic [31:0] held [ND];
    bit          ev [ND];
    bit          ee [ND];
    logic [31:0] ed [ND];
    int          eo [ND];
    int          cyc;

    int n_cmp;
    int n_bad;

    logic [31:0] prog [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int s = 0; s < 8; s++) begin
                hv[d][s] = 1'b0;
                he[d][s] = 1'b0;
                hd[d][s] = 32'h0;
            end
            held[d] = 32'h0;
            ev[d]   = 1'b0;
            ee[d]   = 1'b0;
            ed[d]   = 32'h0;
            eo[d]   = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            int          lat;
            int          s;
            int          k;
            logic [31:0] addr;
            logic [31:0] off;
            logic        bad;
            lat  = lat_of(d);
            s    = cyc % 8;
            addr = aoff + base_of(d);
            off  = addr - base_of(d);
            bad  = (off[1:0] != 2'b00) || (off >= 32'h0000_1000);
            hv[d][s] = nrst && ren;
            he[d][s] = nrst && ren && bad;
            hd[d][s] = bad ? 32'h0000_0013 : mem_m[off[11:2]];
            k = (cyc + 8 - (lat - 1)) % 8;
            ev[d] = hv[d][k];
            ee[d] = he[d][k];
            if (hv[d][k]) held[d] = hd[d][k];
            ed[d] = held[d];
            eo[d] = 0;
            for (int j = 0; j <= lat - 2; j++) begin
                if (hv[d][(cyc + 8 - j) % 8]) eo[d]++;
            end
        end
        if (ld_wen) mem_m[ld_addr] = ld_data;
        cyc++;
    endtask

    task automatic check_all(input string ph);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s.L%0d.valid", ph, lat_of(d)), 32'(got_v[d]), 32'(ev[d]));
            chk($sformatf("%s.L%0d.data", ph, lat_of(d)), got_d[d], ed[d]);
            chk($sformatf("%s.L%0d.err", ph, lat_of(d)), 32'(got_e[d]), 32'(ee[d]));
            chk($sformatf("%s.L%0d.outst", ph, lat_of(d)), 32'(got_o[d]), 32'(eo[d]));
        end
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic fetch(input logic [31:0] o, input string ph);
        ren  = 1'b1;
        aoff = o;
        step(ph);
        ren  = 1'b0;
    endtask

    task automatic idle(input string ph);
        ren    = 1'b0;
        ld_wen = 1'b0;
        step(ph);
    endtask

    task automatic do_reset(input string ph);
        ren    = 1'b0;
        ld_wen = 1'b0;
        nrst   = 1'b0;
        model_reset();
        #1;
        check_all(ph);
        step(ph);
        nrst = 1'b1;
    endtask

    initial begin
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h00A0_0113;
        prog[2] = 32'h0020_81B3;
        prog[3] = 32'h0000_006F;
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        nrst    = 1'b0;
        ren     = 1'b0;
        aoff    = 32'h0;
        ld_wen  = 1'b0;
        ld_addr = '0;
        ld_data = 32'h0;
        model_reset();

        step("rst");
        chk("rst.L1.valid0", 32'(got_v[0]), 32'h0);
        chk("rst.L1.data0", got_d[0], 32'h0);
        nrst = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            ld_wen  = 1'b1;
            ld_addr = 10'(i);
            ld_data = $urandom;
            step("load");
        end
        for (int i = 0; i < 4; i++) begin
            ld_wen  = 1'b1;
            ld_addr = 10'(i);
            ld_data = prog[i];
            step("prog");
        end
        ld_wen = 1'b0;

        // Back-to-back fetch of the program at latency 1.
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4), "seq");
            chk("seq.L1.valid", 32'(got_v[0]), 32'h1);
            chk("seq.L1.data", got_d[0], prog[i]);
            chk("seq.L1.err", 32'(got_e[0]), 32'h0);
        end
        for (int i = 0; i < 5; i++) idle("drain1");

        // Single fetch at latency 3.
        fetch(32'h8, "lat3");
        chk("lat3.outst_a", 32'(got_o[1]), 32'h1);
        idle("lat3");
        chk("lat3.outst_b", 32'(got_o[1]), 32'h1);
        chk("lat3.novalid", 32'(got_v[1]), 32'h0);
        idle("lat3");
        chk("lat3.valid", 32'(got_v[1]), 32'h1);
        chk("lat3.data", got_d[1], 32'h0020_81B3);
        chk("lat3.outst_c", 32'(got_o[1]), 32'h0);
        for (int i = 0; i < 4; i++) idle("drain2");

        // Misaligned and out-of-range fetches.
        fetch(32'h0000_0002, "misal");
        chk("misal.data", got_d[0], 32'h0000_0013);
        chk("misal.err", 32'(got_e[0]), 32'h1);
        fetch(32'h0000_1000, "oor");
        chk("oor.data", got_d[0], 32'h0000_0013);
        chk("oor.err", 32'(got_e[0]), 32'h1);
        for (int i = 0; i < 4; i++) idle("drain3");

        // Load and fetch of the same word at the same edge.
        ld_wen  = 1'b1;
        ld_addr = 10'd1;
        ld_data = 32'hDEAD_BEEF;
        fetch(32'h4, "rbw");
        chk("rbw.old", got_d[0], 32'h00A0_0113);
        ld_wen = 1'b0;
        fetch(32'h4, "rbw");
        chk("rbw.new", got_d[0], 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) idle("drain4");

        // Reset with three requests in flight at latency 4.
        fetch(32'h0, "midrst");
        fetch(32'h4, "midrst");
        fetch(32'h8, "midrst");
        nrst = 1'b0;
        model_reset();
        #1;
        check_all("midrst.low");
        chk("midrst.L4.valid", 32'(got_v[2]), 32'h0);
        chk("midrst.L4.data", got_d[2], 32'h0);
        chk("midrst.L4.err", 32'(got_e[2]), 32'h0);
        step("midrst.low");
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle("midrst.quiet");
            chk("midrst.quiet.L4", 32'(got_v[2]), 32'h0);
        end
        fetch(32'h0, "midrst.new");
        idle("midrst.new");
        idle("midrst.new");
        idle("midrst.new");
        chk("midrst.new.valid", 32'(got_v[2]), 32'h1);
        chk("midrst.new.data", got_d[2], 32'h0050_0093);
        for (int i = 0; i < 4; i++) idle("drain5");

        // Gapped requests; the base-shifted instance sees 0x8000_0000.. addresses.
        fetch(32'h0, "gap");
        idle("gap");
        chk("gap.L2.v0", 32'(got_v[3]), 32'h1);
        fetch(32'h4, "gap");
        chk("gap.L2.v1", 32'(got_v[3]), 32'h0);
        fetch(32'h8, "gap");
        chk("gap.L2.v2", 32'(got_v[3]), 32'h1);
        idle("gap");
        chk("gap.L2.v3", 32'(got_v[3]), 32'h1);
        chk("gap.L2.d3", got_d[3], 32'h0020_81B3);
        idle("gap");
        chk("gap.L2.v4", 32'(got_v[3]), 32'h0);
        fetch(32'hFFFF_FFFC, "below");
        idle("below");
        chk("below.L2.valid", 32'(got_v[3]), 32'h1);
        chk("below.L2.err", 32'(got_e[3]), 32'h1);
        chk("below.L2.data", got_d[3], 32'h0000_0013);
        for (int i = 0; i < 4; i++) idle("drain6");

        // Randomised traffic with loads, collisions and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(99) == 0) begin
                do_reset("rrst");
            end else begin
                ren = ($urandom_range(99) < 70);
                case ($urandom_range(9))
                    0:       aoff = $urandom;
                    1:       aoff = (32'($urandom_range(1023)) << 2) | 32'($urandom_range(3, 1));
                    2:       aoff = 32'h0000_0FF8 + (32'($urandom_range(3)) << 2);
                    3:       aoff = 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
                    default: aoff = 32'($urandom_range(1023)) << 2;
                endcase
                ld_wen  = ($urandom_range(99) < 25);
                ld_addr = ($urandom_range(3) == 0) ? aoff[11:2] : 10'($urandom_range(1023));
                ld_data = $urandom;
                step("rand");
                ld_wen = 1'b0;
            end
        end
        for (int i = 0; i < 6; i++) idle("final");
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("final.L%0d.drained", lat_of(d)), 32'(got_o[d]), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
